// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: widths, ALU opcodes, operand-select encodings.
package rv_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ALUSEL_W  = 4;
    localparam int unsigned REGADDR_W = 5;

    typedef enum logic [ALUSEL_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } aluSel_e;

    localparam logic ASEL_RS1 = 1'b0;
    localparam logic ASEL_PC  = 1'b1;
    localparam logic BSEL_RS2 = 1'b0;
    localparam logic BSEL_IMM = 1'b1;

    localparam logic [REGADDR_W-1:0] REG_X0 = 5'd0;

endpackage

// File: rtl/forward_unit.sv
// Combinational RAW-hazard bypass for one source operand; EX/MEM beats MEM/WB, x0 never forwards.
module forward_unit
    import rv_pkg::*;
#(
    parameter int unsigned WIDTH_DATA_LENGTH    = DATA_W,
    parameter int unsigned WIDTH_REGADDR_LENGTH = REGADDR_W
) (
    input  logic [WIDTH_REGADDR_LENGTH-1:0] Rs,
    input  logic [WIDTH_DATA_LENGTH-1:0]    RegData,
    input  logic [WIDTH_REGADDR_LENGTH-1:0] ExMemRd,
    input  logic                            ExMemRegWEn,
    input  logic [WIDTH_DATA_LENGTH-1:0]    ExMemResult,
    input  logic [WIDTH_REGADDR_LENGTH-1:0] MemWbRd,
    input  logic                            MemWbRegWEn,
    input  logic [WIDTH_DATA_LENGTH-1:0]    MemWbResult,
    output logic [WIDTH_DATA_LENGTH-1:0]    FwdData
);

    localparam logic [WIDTH_REGADDR_LENGTH-1:0] X0 = WIDTH_REGADDR_LENGTH'(REG_X0);

    logic exMemHit;
    logic memWbHit;

    assign exMemHit = ExMemRegWEn && (ExMemRd != X0) && (ExMemRd == Rs);
    assign memWbHit = MemWbRegWEn && (MemWbRd != X0) && (MemWbRd == Rs);

    always_comb begin
        FwdData = RegData;
        if (exMemHit) begin
            FwdData = ExMemResult;
        end else if (memWbHit) begin
            FwdData = MemWbResult;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with operand forwarding and A/B select muxes feeding the ALU.
module alu_operand_stage
    import rv_pkg::*;
#(
    parameter int unsigned WIDTH_DATA_LENGTH    = DATA_W,
    parameter int unsigned WIDTH_ALUSEL_LENGTH  = ALUSEL_W,
    parameter int unsigned WIDTH_REGADDR_LENGTH = REGADDR_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            Stall,
    input  logic                            Flush,
    input  logic                            InValid,
    input  logic [WIDTH_DATA_LENGTH-1:0]    InPC,
    input  logic [WIDTH_DATA_LENGTH-1:0]    InRs1Data,
    input  logic [WIDTH_DATA_LENGTH-1:0]    InRs2Data,
    input  logic [WIDTH_DATA_LENGTH-1:0]    InImm,
    input  logic [WIDTH_REGADDR_LENGTH-1:0] InRs1,
    input  logic [WIDTH_REGADDR_LENGTH-1:0] InRs2,
    input  logic [WIDTH_REGADDR_LENGTH-1:0] InRd,
    input  logic [WIDTH_ALUSEL_LENGTH-1:0]  InALUSel,
    input  logic                            InASel,
    input  logic                            InBSel,
    input  logic                            InRegWEn,
    input  logic [WIDTH_REGADDR_LENGTH-1:0] ExMemRd,
    input  logic                            ExMemRegWEn,
    input  logic [WIDTH_DATA_LENGTH-1:0]    ExMemResult,
    input  logic [WIDTH_REGADDR_LENGTH-1:0] MemWbRd,
    input  logic                            MemWbRegWEn,
    input  logic [WIDTH_DATA_LENGTH-1:0]    MemWbResult,
    output logic [WIDTH_DATA_LENGTH-1:0]    DataA,
    output logic [WIDTH_DATA_LENGTH-1:0]    DataB,
    output logic [WIDTH_ALUSEL_LENGTH-1:0]  ALUSel,
    output logic [WIDTH_DATA_LENGTH-1:0]    StoreData,
    output logic                            OutValid,
    output logic [WIDTH_DATA_LENGTH-1:0]    OutPC,
    output logic [WIDTH_REGADDR_LENGTH-1:0] OutRd,
    output logic                            OutRegWEn
);

    logic                            validQ;
    logic [WIDTH_DATA_LENGTH-1:0]    pcQ;
    logic [WIDTH_DATA_LENGTH-1:0]    immQ;
    logic [WIDTH_DATA_LENGTH-1:0]    rs1DataQ;
    logic [WIDTH_DATA_LENGTH-1:0]    rs2DataQ;
    logic [WIDTH_REGADDR_LENGTH-1:0] rs1Q;
    logic [WIDTH_REGADDR_LENGTH-1:0] rs2Q;
    logic [WIDTH_REGADDR_LENGTH-1:0] rdQ;
    logic [WIDTH_ALUSEL_LENGTH-1:0]  aluSelQ;
    logic                            aSelQ;
    logic                            bSelQ;
    logic                            regWEnQ;

    logic [WIDTH_DATA_LENGTH-1:0]    fwdRs1;
    logic [WIDTH_DATA_LENGTH-1:0]    fwdRs2;

    // A flush, or an invalid decode slot when not stalled, loads the reset bubble.
    always_ff @(posedge clk) begin
        if (rst || Flush || (!Stall && !InValid)) begin
            validQ   <= 1'b0;
            pcQ      <= '0;
            immQ     <= '0;
            rs1DataQ <= '0;
            rs2DataQ <= '0;
            rs1Q     <= '0;
            rs2Q     <= '0;
            rdQ      <= '0;
            aluSelQ  <= '0;
            aSelQ    <= 1'b0;
            bSelQ    <= 1'b0;
            regWEnQ  <= 1'b0;
        end else if (Stall) begin
            // Latch bypassed values so they survive the producer retiring mid-stall.
            rs1DataQ <= fwdRs1;
            rs2DataQ <= fwdRs2;
        end else begin
            validQ   <= 1'b1;
            pcQ      <= InPC;
            immQ     <= InImm;
            rs1DataQ <= InRs1Data;
            rs2DataQ <= InRs2Data;
            rs1Q     <= InRs1;
            rs2Q     <= InRs2;
            rdQ      <= InRd;
            aluSelQ  <= InALUSel;
            aSelQ    <= InASel;
            bSelQ    <= InBSel;
            regWEnQ  <= InRegWEn;
        end
    end

    forward_unit #(
        .WIDTH_DATA_LENGTH    (WIDTH_DATA_LENGTH),
        .WIDTH_REGADDR_LENGTH (WIDTH_REGADDR_LENGTH)
    ) u_fwdRs1 (
        .Rs          (rs1Q),
        .RegData     (rs1DataQ),
        .ExMemRd     (ExMemRd),
        .ExMemRegWEn (ExMemRegWEn),
        .ExMemResult (ExMemResult),
        .MemWbRd     (MemWbRd),
        .MemWbRegWEn (MemWbRegWEn),
        .MemWbResult (MemWbResult),
        .FwdData     (fwdRs1)
    );

    forward_unit #(
        .WIDTH_DATA_LENGTH    (WIDTH_DATA_LENGTH),
        .WIDTH_REGADDR_LENGTH (WIDTH_REGADDR_LENGTH)
    ) u_fwdRs2 (
        .Rs          (rs2Q),
        .RegData     (rs2DataQ),
        .ExMemRd     (ExMemRd),
        .ExMemRegWEn (ExMemRegWEn),
        .ExMemResult (ExMemResult),
        .MemWbRd     (MemWbRd),
        .MemWbRegWEn (MemWbRegWEn),
        .MemWbResult (MemWbResult),
        .FwdData     (fwdRs2)
    );

    assign DataA     = (aSelQ == ASEL_PC)  ? pcQ  : fwdRs1;
    assign DataB     = (bSelQ == BSEL_IMM) ? immQ : fwdRs2;
    assign StoreData = fwdRs2;
    assign ALUSel    = aluSelQ;
    assign OutValid  = validQ;
    assign OutPC     = pcQ;
    assign OutRd     = rdQ;
    assign OutRegWEn = regWEnQ & validQ;

endmodule
